// File: rtl/transmissor_serial_paridade_pkg.sv
// Shared definitions for the parity serial transmitter: FSM encoding,
// frame length and the parity rule also used by the parity verifier.
package transmissor_serial_paridade_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  localparam int BITS_QUADRO      = 11;
  localparam int LARGURA_CONTADOR = 16;

  // Parity bit that makes (ones in d + bit) odd when impar=1, even otherwise.
  function automatic logic calc_paridade(input logic [7:0] d, input logic impar);
    return (^d) ^ impar;
  endfunction

endpackage

// File: rtl/transmissor_serial_paridade_if.sv
// Byte handshake between a sender (master) and the serial transmitter (slave).
interface transmissor_serial_paridade_if;

  logic [7:0] dados;
  logic       valido;
  logic       pronto;

  modport master (output dados, output valido, input pronto);
  modport slave  (input dados, input valido, output pronto);

endinterface

// File: rtl/transmissor_serial_paridade_contador.sv
// Bit-period down-counter: reloads to CICLOS_POR_BIT-1 on carga and flags
// expiry while enabled at zero.
module contador_bit
  import transmissor_serial_paridade_pkg::*;
#(
  parameter int CICLOS_POR_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic carga,
  input  logic habilita,
  output logic expirou
);

  localparam logic [LARGURA_CONTADOR-1:0] RECARGA = LARGURA_CONTADOR'(CICLOS_POR_BIT - 1);

  logic [LARGURA_CONTADOR-1:0] contagem;

  always_ff @(posedge clk) begin
    if (reset) begin
      contagem <= '0;
    end else if (carga) begin
      contagem <= RECARGA;
    end else if (habilita && (contagem != '0)) begin
      contagem <= contagem - LARGURA_CONTADOR'(1);
    end
  end

  assign expirou = habilita && (contagem == '0);

endmodule

// File: rtl/transmissor_serial_paridade.sv
// Serial transmitter: start, 8 data bits LSB first, parity, stop; each bit
// held CICLOS_POR_BIT cycles.
//   state    | meaning
//   OCIOSO   | line idle high, pronto=1, waiting for valido
//   INICIO   | start bit (0)
//   DADOS    | data bits 0..7, indice selects the current bit
//   PARIDADE | parity bit
//   PARADA   | stop bit (1), returns to OCIOSO
module transmissor_serial_paridade
  import transmissor_serial_paridade_pkg::*;
#(
  parameter int CICLOS_POR_BIT = 4,
  parameter bit PARIDADE_IMPAR = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  transmissor_serial_paridade_if.slave  barramento,
  output logic                          tx,
  output logic                          ocupado,
  output logic                          bit_paridade
);

  estado_t    estado;
  logic [7:0] registro;
  logic [2:0] indice;
  logic       pronto_q;
  logic       aceita;
  logic       expirou;
  logic       carga;
  logic       habilita;

  assign aceita   = barramento.valido && pronto_q;
  assign habilita = (estado != OCIOSO);
  // No reload after the stop bit: the counter idles until the next acceptance.
  assign carga    = aceita || (expirou && (estado != PARADA));

  assign barramento.pronto = pronto_q;

  contador_bit #(
    .CICLOS_POR_BIT(CICLOS_POR_BIT)
  ) u_contador_bit (
    .clk      (clk),
    .reset    (reset),
    .carga    (carga),
    .habilita (habilita),
    .expirou  (expirou)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado       <= OCIOSO;
      tx           <= 1'b1;
      pronto_q     <= 1'b1;
      ocupado      <= 1'b0;
      bit_paridade <= 1'b0;
      indice       <= 3'd0;
      registro     <= 8'd0;
    end else begin
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            registro     <= barramento.dados;
            bit_paridade <= calc_paridade(barramento.dados, PARIDADE_IMPAR);
            tx           <= 1'b0;
            pronto_q     <= 1'b0;
            ocupado      <= 1'b1;
            estado       <= INICIO;
          end
        end
        INICIO: begin
          if (expirou) begin
            tx     <= registro[0];
            indice <= 3'd0;
            estado <= DADOS;
          end
        end
        DADOS: begin
          if (expirou) begin
            if (indice == 3'd7) begin
              tx     <= bit_paridade;
              estado <= PARIDADE;
            end else begin
              // Bit 0 of the shift register is always the bit on the line.
              tx       <= registro[1];
              registro <= {1'b0, registro[7:1]};
              indice   <= indice + 3'd1;
            end
          end
        end
        PARIDADE: begin
          if (expirou) begin
            tx     <= 1'b1;
            estado <= PARADA;
          end
        end
        PARADA: begin
          if (expirou) begin
            pronto_q <= 1'b1;
            ocupado  <= 1'b0;
            estado   <= OCIOSO;
          end
        end
        default: begin
          tx       <= 1'b1;
          pronto_q <= 1'b1;
          ocupado  <= 1'b0;
          estado   <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmissor_serial_paridade.sv
// Bench for transmissor_serial_paridade: one odd-parity instance (4 cycles/bit)
// and one even-parity instance (3 cycles/bit) checked against a frame model.
module tb_transmissor_serial_paridade;
  import transmissor_serial_paridade_pkg::*;

  localparam int C_A = 4;
  localparam int C_B = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  transmissor_serial_paridade_if if_a ();
  transmissor_serial_paridade_if if_b ();

  logic tx_a, ocupado_a, par_a;
  logic tx_b, ocupado_b, par_b;

  transmissor_serial_paridade #(.CICLOS_POR_BIT(C_A), .PARIDADE_IMPAR(1)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .barramento   (if_a.slave),
    .tx           (tx_a),
    .ocupado      (ocupado_a),
    .bit_paridade (par_a)
  );

  transmissor_serial_paridade #(.CICLOS_POR_BIT(C_B), .PARIDADE_IMPAR(0)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .barramento   (if_b.slave),
    .tx           (tx_b),
    .ocupado      (ocupado_b),
    .bit_paridade (par_b)
  );

  int checks  = 0;
  int errors  = 0;
  int ciclo   = 0;
  int inicio_ult = 0;

  always @(posedge clk) ciclo++;

  // Reference frame: start, d[0..7], parity from the count of ones, stop.
  function automatic logic bit_quadro(input logic [7:0] d, input bit impar, input int idx);
    int  ones;
    logic p;
    ones = $countones(d);
    p = impar ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return p;
    return 1'b1;
  endfunction

  function automatic logic tx_de(input int s);      return (s != 0) ? tx_b : tx_a; endfunction
  function automatic logic pronto_de(input int s);  return (s != 0) ? if_b.pronto : if_a.pronto; endfunction
  function automatic logic ocupado_de(input int s); return (s != 0) ? ocupado_b : ocupado_a; endfunction
  function automatic logic par_de(input int s);     return (s != 0) ? par_b : par_a; endfunction
  function automatic int   ciclos_de(input int s);  return (s != 0) ? C_B : C_A; endfunction
  function automatic bit   impar_de(input int s);   return (s != 0) ? 1'b0 : 1'b1; endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_valido(input int s, input logic v);
    if (s != 0) if_b.valido = v; else if_a.valido = v;
  endtask

  task automatic set_dados(input int s, input logic [7:0] d);
    if (s != 0) if_b.dados = d; else if_a.dados = d;
  endtask

  task automatic iniciar(input int s, input logic [7:0] d, input bit manter);
    int espera;
    espera = 0;
    @(negedge clk);
    while (!pronto_de(s) && espera < 200) begin
      @(negedge clk);
      espera++;
    end
    chk("pronto_antes", pronto_de(s), 1'b1);
    set_dados(s, d);
    set_valido(s, 1'b1);
    @(posedge clk);
    #1;
    if (!manter) set_valido(s, 1'b0);
  endtask

  // Samples the whole frame after acceptance, then the first idle cycle.
  task automatic verificar_quadro(input int s, input logic [7:0] d, input int troca_em,
                                  input logic [7:0] troca_val, input int pulso_em, input int solta_em);
    int n;
    int ones;
    logic [10:0] rec;
    logic erro;
    n = ciclos_de(s);
    rec = '0;
    for (int k = 0; k < BITS_QUADRO * n; k++) begin
      @(negedge clk);
      if (k == 0) inicio_ult = ciclo;
      chk($sformatf("tx_bit%0d_c%0d", k / n, k % n), tx_de(s), bit_quadro(d, impar_de(s), k / n));
      chk("pronto_quadro", pronto_de(s), 1'b0);
      chk("ocupado_quadro", ocupado_de(s), 1'b1);
      if ((k % n) == (n / 2)) rec[k / n] = tx_de(s);
      if (k == troca_em) set_dados(s, troca_val);
      if (k == pulso_em) set_valido(s, 1'b1);
      if (k == solta_em) set_valido(s, 1'b0);
    end
    chk("bit_paridade", par_de(s), bit_quadro(d, impar_de(s), 9));
    ones = $countones(rec[9:1]);
    erro = impar_de(s) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    chk("erro_verificador", erro, 1'b0);
    @(negedge clk);
    chk("pronto_fim", pronto_de(s), 1'b1);
    chk("ocupado_fim", ocupado_de(s), 1'b0);
    chk("tx_ocioso", tx_de(s), 1'b1);
  endtask

  initial begin
    int inicio_ant;
    int s;
    logic [7:0] d;

    reset = 1'b1;
    if_a.valido = 1'b0; if_a.dados = 8'h00;
    if_b.valido = 1'b0; if_b.dados = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_a", tx_a, 1'b1);
    chk("rst_pronto_a", if_a.pronto, 1'b1);
    chk("rst_ocupado_a", ocupado_a, 1'b0);
    chk("rst_par_a", par_a, 1'b0);
    chk("rst_tx_b", tx_b, 1'b1);
    chk("rst_pronto_b", if_b.pronto, 1'b1);
    reset = 1'b0;

    // All-zero byte, then 0x07.
    iniciar(0, 8'h00, 1'b0);
    verificar_quadro(0, 8'h00, -1, 8'h00, -1, -1);
    iniciar(0, 8'h07, 1'b0);
    verificar_quadro(0, 8'h07, -1, 8'h00, -1, -1);

    // Back-to-back with valido held high.
    iniciar(0, 8'hFF, 1'b1);
    verificar_quadro(0, 8'hFF, 3, 8'h01, -1, -1);
    inicio_ant = inicio_ult;
    verificar_quadro(0, 8'h01, -1, 8'h00, -1, 0);
    chk_int("espaco_inicio", inicio_ult - inicio_ant, BITS_QUADRO * C_A + 1);

    // Data changes mid-frame must not leak into the frame.
    iniciar(0, 8'hA5, 1'b0);
    verificar_quadro(0, 8'hA5, 2, 8'h5A, -1, -1);

    // Even parity, valido pulsed while busy.
    iniciar(1, 8'hFE, 1'b0);
    verificar_quadro(1, 8'hFE, -1, 8'h00, 5, 8);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("sem_aceite_tx", tx_b, 1'b1);
      chk("sem_aceite_pronto", if_b.pronto, 1'b1);
    end

    // Random bytes on both instances.
    for (int i = 0; i < 8; i++) begin
      s = i % 2;
      d = 8'($urandom);
      iniciar(s, d, 1'b0);
      verificar_quadro(s, d, int'($urandom_range(0, 30)), 8'($urandom), -1, -1);
    end

    // Reset at cycle 20 of a frame.
    iniciar(0, 8'h3C, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("pre_reset_tx", tx_a, bit_quadro(8'h3C, 1'b1, k / C_A));
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_tx", tx_a, 1'b1);
    chk("abort_pronto", if_a.pronto, 1'b1);
    chk("abort_ocupado", ocupado_a, 1'b0);
    chk("abort_par", par_a, 1'b0);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      chk("abort_idle_tx", tx_a, 1'b1);
    end

    // Reset wins over acceptance in the same cycle.
    @(negedge clk);
    if_a.dados = 8'h81;
    if_a.valido = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    if_a.valido = 1'b0;
    for (int k = 0; k < 2 * C_A; k++) begin
      @(negedge clk);
      chk("prio_tx", tx_a, 1'b1);
      chk("prio_pronto", if_a.pronto, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/transmissor_serial_paridade.md
TRANSMISSOR_SERIAL_PARIDADE -- requirements
Module: transmissor_serial_paridade

Interface
REQ-001 The block SHALL have parameter CICLOS_POR_BIT, default 4, giving the clock cycles each serial bit is held; legal range is 2 to 65535.
REQ-002 The block SHALL have parameter PARIDADE_IMPAR, default 1, where 1 selects odd parity and 0 selects even parity.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 dados  input  8  byte to transmit, sampled only at acceptance.
REQ-006 valido  input  1  sender asserts that dados holds a byte to send.
REQ-007 pronto  output  1  block can accept a byte this cycle.
REQ-008 tx  output  1  serial line, idle high.
REQ-009 ocupado  output  1  a frame is in progress.
REQ-010 bit_paridade  output  1  parity bit of the byte last accepted, held until the next acceptance.

Function
REQ-011 The block SHALL accept a byte on a rising edge where valido=1 and pronto=1; no other condition SHALL cause acceptance.
REQ-012 At acceptance the block SHALL register dados into a shift register; changes on dados afterwards SHALL NOT affect the frame.
REQ-013 At acceptance bit_paridade SHALL be computed so that the count of ones in dados plus bit_paridade is odd if PARIDADE_IMPAR=1, and even otherwise.
REQ-014 Frame order SHALL be: start bit (0), dados[0] through dados[7] LSB first, bit_paridade, stop bit (1); 11 bits total.
REQ-015 Each frame bit SHALL drive tx for exactly CICLOS_POR_BIT cycles, using a down-counter reloaded to CICLOS_POR_BIT-1 at every bit boundary.
REQ-016 The FSM SHALL have states OCIOSO, INICIO, DADOS, PARIDADE and PARADA; a 3-bit index SHALL count data bits 0..7 in DADOS.
REQ-017 FSM transitions: OCIOSO->INICIO on acceptance; INICIO->DADOS, DADOS->PARIDADE (after bit 7) and PARIDADE->PARADA each at counter expiry; PARADA->OCIOSO at counter expiry.
REQ-018 tx SHALL be registered; it SHALL go low on the first rising edge after acceptance (1-cycle latency) and stay high in OCIOSO.
REQ-019 pronto SHALL be 1 only in OCIOSO, and ocupado SHALL be the complement of pronto.
REQ-020 A full frame SHALL last 11*CICLOS_POR_BIT cycles, after which at least one OCIOSO cycle SHALL precede the next start bit.
REQ-021 Back-to-back: if valido is held high, the next byte SHALL be accepted in the first OCIOSO cycle, so the next start bit begins 11*CICLOS_POR_BIT+1 cycles after the previous one.
REQ-022 valido asserted while ocupado=1 SHALL be ignored; the sender must hold it until pronto=1.

Reset
REQ-023 When reset=1 at a rising edge: state=OCIOSO, tx=1, pronto=1, ocupado=0, bit_paridade=0, counter=0, bit index=0, shift register=0.
REQ-024 Reset during a frame SHALL abort it: tx=1 from the next edge, and no partial frame SHALL resume.
REQ-025 Reset SHALL take priority over acceptance in the same cycle; that byte SHALL be dropped.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding, the frame length constant (11) and the parity-function definition; the existing parity verifier SHALL use the same parity definition.
REQ-027 The bit-period down-counter SHALL be one sub-module, contador_bit, with load, enable and expiry signals; all other logic stays in the top module.

Verification
REQ-028 Reset, then dados=8'h00 with valido pulsed (CICLOS_POR_BIT=4) -> tx sequence 0,00000000,1,1, each bit 4 cycles; bit_paridade=1; pronto returns high after 44 cycles.
REQ-029 dados=8'b00000111 -> data bits on tx 1,1,1,0,0,0,0,0; bit_paridade=0; received frame checks with erro=0 in the parity verifier.
REQ-030 valido held high with dados=8'hFF then 8'h01 -> second start bit 45 cycles after the first; parity bits 1 then 0.
REQ-031 Change dados from 8'hA5 to 8'h5A during the frame -> transmitted data bits remain 8'hA5 (1,0,1,0,0,1,0,1).
REQ-032 Assert reset at cycle 20 of a frame -> tx=1, pronto=1 on the next edge, and no further low bits until a new acceptance.
REQ-033 PARIDADE_IMPAR=0 with dados=8'b11111110 -> bit_paridade=1; valido pulsed while ocupado=1 -> no acceptance and the frame is unchanged.
